mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the Y86 CPU, directly downstream of the execute ALU module. Accepts one executed instruction (icode, Cnd, valE, valA, valP, status) per valid/ready handshake. Performs at most one 32-bit data-memory read or write over a request/acknowledge port, then presents valM, the updated status and the pass-through fields to write-back. Once a halting or faulting instruction has been emitted, the stage stops accepting input until reset.

## Interface
- DATA_WID, 32: data/address width (matches `DATA_WID` in the shared header).
- MEM_BYTES, 4096: data-memory size in bytes; used only when MEM_ADDR_CHECK_EN is defined.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- icode  in  4  instruction code.
- Cnd  in  1  condition flag from execute.
- valE  in  DATA_WID  ALU result.
- valA  in  DATA_WID  register operand A.
- valP  in  DATA_WID  next-PC value.
- in_stat  in  2  incoming status: AOK=0, HLT=1, ADR=2, INS=3.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DATA_WID  byte address.
- mem_wdata  out  DATA_WID  write data.
- mem_ack  in  1  request completes this cycle.
- mem_rdata  in  DATA_WID  read data; valid in the mem_ack cycle.
- out_valid  out  1  result valid to write-back.
- out_ready  in  1  write-back accepts.
- out_icode, out_Cnd, out_valE, out_valM, out_stat  out  4/1/DATA_WID/DATA_WID/2  registered results.

## Operation
- States: IDLE, REQ, DONE, HALTED.
- Input is accepted in IDLE when in_valid is high. Accepted fields are registered.
- Access selection:
  - Read at valE: icode 5 (mrmovl).
  - Read at valA: icode 9 (ret) and B (popl).
  - Write valA to valE: icode 4 (rmmovl) and A (pushl).
  - Write valP to valE: icode 8 (call).
  - No access for all other codes.
- Bypass to DONE (no memory access) when any of the following holds:
  - in_stat != AOK, or icode == 0 (halt): out_stat = in_stat, or HLT for icode 0.
  - icode > B: out_stat = INS.
  - The instruction has no memory access.
- Otherwise go to REQ.
- REQ: mem_req = 1, with mem_we, mem_addr and mem_wdata stable from the registered fields. On mem_ack:
  - Reads capture mem_rdata into out_valM.
  - Go to DONE.
- out_valM is 0 for non-read instructions.
- DONE: out_valid = 1; outputs are held stable until out_ready. On handshake:
  - Go to HALTED if out_stat != AOK.
  - Otherwise go to IDLE.
- HALTED: in_ready = 0, out_valid = 0, mem_req = 0. Left only by reset.
- Pass-through: out_icode = icode, out_Cnd = Cnd, out_valE = valE.

## Timing
- Reset (asynchronous): state = IDLE. in_ready = 1 once reset deasserts. All other outputs are 0, including mem_req, out_valid and out_stat (= AOK).
- Reset asserted during REQ drops mem_req immediately. The outstanding access is abandoned, with no retry.
- Bypass path: accept edge k, out_valid high in cycle k+1.
- Memory path: mem_req high in cycle k+1. mem_ack may arrive in that cycle at the earliest, giving out_valid in cycle k+2. There is no timeout.
- mem_ack while mem_req is low is ignored.
- in_ready is low in REQ and DONE. There is no overlap, so throughput is at most one instruction per 2 cycles.
- When out_ready is high in the first DONE cycle, the next input can be accepted one cycle later. Going DONE → IDLE → accept adds one cycle.

## Configuration
- MEM_ADDR_CHECK_EN defined: before entering REQ, an address with addr > MEM_BYTES-4 (unsigned) bypasses to DONE with out_stat = ADR. No request is issued.
- MEM_ADDR_CHECK_EN undefined: no bounds check. Every memory instruction issues a request, and ADR is produced only by propagation from in_stat.

## Structure
- The shared header holds DATA_WID, the icode constants (IHALT…IPOPL) and the status codes (SAOK, SHLT, SADR, SINS). The state encoding is local to this block.
- One combinational sub-module, mem_sel, maps icode/valA/valE/valP to rd, wr, addr and wdata. The FSM and registers live in mem_stage.

## Test plan
- rmmovl: icode=4, valE=0x100, valA=0xDEADBEEF; ack after 3 cycles → one request with we=1, addr=0x100, wdata=0xDEADBEEF; then out_valid with out_stat=AOK.
- mrmovl: icode=5, valE=0x20; mem_rdata=0x12345678 with mem_ack in the first REQ cycle → out_valM=0x12345678, out_valid 2 cycles after accept.
- OPl: icode=6, valE=7 → no mem_req, out_valid 1 cycle after accept, out_valE=7, out_valM=0.
- halt: icode=0 → out_stat=HLT; after the output handshake in_ready stays 0 for 10 cycles despite in_valid=1.
- Address check (MEM_ADDR_CHECK_EN, MEM_BYTES=4096): call with valE=0xFFE → no mem_req, out_stat=ADR. Without the macro → write to 0xFFE of valP.
- Back-pressure and reset: hold out_ready=0 for 5 cycles → outputs stable. Asserting rst during REQ drops mem_req in the same cycle; after release, in_ready=1 and out_valid=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared Y86 definitions for the memory stage: data width, instruction codes,
// status codes and the status-precedence helper used when an input is accepted.
package mem_stage_pkg;

  localparam int DATA_WID = 32;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  // An upstream fault wins over halt, which wins over an unknown opcode.
  function automatic logic [1:0] base_stat(input logic [1:0] in_stat,
                                           input logic [3:0] icode);
    if (in_stat != SAOK)    return in_stat;
    else if (icode == IHALT) return SHLT;
    else if (icode > IPOPL)  return SINS;
    else                     return SAOK;
  endfunction

endpackage

// File: rtl/mem_sel.sv
// Combinational access decoder: maps an instruction to its memory read/write
// intent, byte address and write data.
module mem_sel #(
  parameter int DATA_WID = mem_stage_pkg::DATA_WID
) (
  input  logic [3:0]          icode,
  input  logic [DATA_WID-1:0] val_a,
  input  logic [DATA_WID-1:0] val_e,
  input  logic [DATA_WID-1:0] val_p,
  output logic                rd,
  output logic                wr,
  output logic [DATA_WID-1:0] addr,
  output logic [DATA_WID-1:0] wdata
);
  import mem_stage_pkg::*;

  // Stack pops read at the old stack pointer (valA); everything else uses valE.
  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    case (icode)
      IMRMOVL: begin
        rd   = 1'b1;
        addr = val_e;
      end
      IRET, IPOPL: begin
        rd   = 1'b1;
        addr = val_a;
      end
      IRMMOVL, IPUSHL: begin
        wr    = 1'b1;
        addr  = val_e;
        wdata = val_a;
      end
      ICALL: begin
        wr    = 1'b1;
        addr  = val_e;
        wdata = val_p;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Y86 memory-access stage: one instruction per handshake, at most one data
// access, then results to write-back. Optional bounds check: MEM_ADDR_CHECK_EN.
module mem_stage #(
  parameter int DATA_WID  = mem_stage_pkg::DATA_WID,
  parameter int MEM_BYTES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          icode,
  input  logic                Cnd,
  input  logic [DATA_WID-1:0] valE,
  input  logic [DATA_WID-1:0] valA,
  input  logic [DATA_WID-1:0] valP,
  input  logic [1:0]          in_stat,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_WID-1:0] mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_icode,
  output logic                out_Cnd,
  output logic [DATA_WID-1:0] out_valE,
  output logic [DATA_WID-1:0] out_valM,
  output logic [1:0]          out_stat
);
  import mem_stage_pkg::*;

  typedef enum logic [1:0] {IDLE, REQ, DONE, HALTED} state_t;

`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [DATA_WID-1:0] ADDR_LIMIT = DATA_WID'(MEM_BYTES - 4);

  state_t              state, state_nx;
  logic                sel_rd, sel_wr;
  logic [DATA_WID-1:0] sel_addr, sel_wdata;
  logic                addr_bad;
  logic [1:0]          acc_stat;
  logic                acc_bypass;
  logic                accept;

  mem_sel #(.DATA_WID(DATA_WID)) u_sel (
    .icode (icode),
    .val_a (valA),
    .val_e (valE),
    .val_p (valP),
    .rd    (sel_rd),
    .wr    (sel_wr),
    .addr  (sel_addr),
    .wdata (sel_wdata)
  );

  assign addr_bad = CHECK_EN && (sel_rd || sel_wr) && (sel_addr > ADDR_LIMIT);
  assign accept   = (state == IDLE) && in_valid;

  // Status of the incoming instruction; any non-AOK result skips the access.
  always_comb begin
    acc_stat = base_stat(in_stat, icode);
    if (acc_stat == SAOK && addr_bad) acc_stat = SADR;
    acc_bypass = (acc_stat != SAOK) || !(sel_rd || sel_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = acc_bypass ? DONE : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (out_stat != SAOK) ? HALTED : IDLE;
      end
      HALTED: ;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are frozen at accept so they stay stable for the whole REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_icode <= '0;
      out_Cnd   <= 1'b0;
      out_valE  <= '0;
      out_valM  <= '0;
      out_stat  <= SAOK;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept) begin
      out_icode <= icode;
      out_Cnd   <= Cnd;
      out_valE  <= valE;
      out_valM  <= '0;
      out_stat  <= acc_stat;
      mem_we    <= sel_wr;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
    end else if (state == REQ && mem_ack && !mem_we) begin
      out_valM  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for the normal access paths plus
// sequences for back-pressure, reset mid-request, faults and halt lock-up.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0;
  logic        Cnd = 1'b0;
  logic [31:0] valE = '0, valA = '0, valP = '0;
  logic [1:0]  in_stat = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_icode;
  logic        out_Cnd;
  logic [31:0] out_valE, out_valM;
  logic [1:0]  out_stat;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .Cnd(Cnd), .valE(valE), .valA(valA), .valP(valP),
    .in_stat(in_stat), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_Cnd(out_Cnd), .out_valE(out_valE),
    .out_valM(out_valM), .out_stat(out_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] val_e, val_a, val_p, rdata;
    logic [1:0]  stat_in;
    int          delay;
    logic        exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_valm;
    logic [1:0]  exp_stat;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mkVec(
    input logic [3:0] ic, input logic cn, input logic [31:0] ve, va, vp, rd,
    input logic [1:0] st, input int dl, input logic er, ew,
    input logic [31:0] ea, ewd, evm, input logic [1:0] es, input int el);
    vec_t v;
    v.icode = ic; v.cnd = cn; v.val_e = ve; v.val_a = va; v.val_p = vp;
    v.rdata = rd; v.stat_in = st; v.delay = dl; v.exp_req = er; v.exp_we = ew;
    v.exp_addr = ea; v.exp_wdata = ewd; v.exp_valm = evm; v.exp_stat = es;
    v.exp_lat = el;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Called just after a negedge; drives the instruction, services the memory
  // port with the vector's ack delay and checks everything up to out_valid.
  task automatic applyStimulus(input vec_t v, input string tag);
    int c, reqs;
    bit done;
    logic [31:0] req_addr, req_wdata;
    logic req_we;
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    icode = v.icode; Cnd = v.cnd; valE = v.val_e; valA = v.val_a;
    valP = v.val_p; in_stat = v.stat_in; in_valid = 1'b1;
    reqs = 0; done = 1'b0; c = 0;
    req_addr = '0; req_wdata = '0; req_we = 1'b0;
    while (!done && c < 40) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      c++;
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
        end
        if (reqs == v.delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (out_valid) done = 1'b1;
    end
    checkOutput({tag, " out_valid reached"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, 32'(c), 32'(v.exp_lat));
    checkOutput({tag, " req cycles"}, 32'(reqs), v.exp_req ? 32'(v.delay + 1) : 32'd0);
    if (v.exp_req) begin
      checkOutput({tag, " mem_addr"}, req_addr, v.exp_addr);
      checkOutput({tag, " mem_we"}, 32'(req_we), 32'(v.exp_we));
      if (v.exp_we) checkOutput({tag, " mem_wdata"}, req_wdata, v.exp_wdata);
    end
    checkOutput({tag, " out_icode"}, 32'(out_icode), 32'(v.icode));
    checkOutput({tag, " out_Cnd"}, 32'(out_Cnd), 32'(v.cnd));
    checkOutput({tag, " out_valE"}, out_valE, v.val_e);
    checkOutput({tag, " out_valM"}, out_valM, v.exp_valm);
    checkOutput({tag, " out_stat"}, 32'(out_stat), 32'(v.exp_stat));
  endtask

  task automatic finishHandshake(input logic exp_ready, input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after handshake"}, 32'(in_ready), 32'(exp_ready));
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    logic [31:0] held_e;
    logic exp_ready;

    vecs[0] = mkVec(IRMMOVL, 0, 'h100, 'hDEADBEEF, 'h6, 0, SAOK, 3, 1, 1, 'h100, 'hDEADBEEF, 0, SAOK, 5);
    vecs[1] = mkVec(IMRMOVL, 1, 'h20, 'h5, 'hA, 'h12345678, SAOK, 0, 1, 0, 'h20, 0, 'h12345678, SAOK, 2);
    vecs[2] = mkVec(IOPL, 1, 7, 3, 'hC, 0, SAOK, 0, 0, 0, 0, 0, 0, SAOK, 1);
    vecs[3] = mkVec(ICALL, 0, 'h200, 'h55, 'h1234, 0, SAOK, 1, 1, 1, 'h200, 'h1234, 0, SAOK, 3);
    vecs[4] = mkVec(IRET, 0, 'h304, 'h300, 'h10, 'hCAFE0001, SAOK, 2, 1, 0, 'h300, 0, 'hCAFE0001, SAOK, 4);
    vecs[5] = mkVec(IPOPL, 0, 'h84, 'h80, 'h20, 'hA5A5, SAOK, 0, 1, 0, 'h80, 0, 'hA5A5, SAOK, 2);
    vecs[6] = mkVec(IPUSHL, 0, 'h7C, 'h11223344, 'h22, 0, SAOK, 0, 1, 1, 'h7C, 'h11223344, 0, SAOK, 2);
    vecs[7] = mkVec(IJXX, 0, 'h40, 0, 'h30, 0, SAOK, 0, 0, 0, 0, 0, 0, SAOK, 1);
    vecs[8] = mkVec(IMRMOVL, 0, 'hFFC, 0, 0, 'h0BADF00D, SAOK, 1, 1, 0, 'hFFC, 0, 'h0BADF00D, SAOK, 3);
    vecs[9] = mkVec(INOP, 1, 0, 0, 0, 0, SAOK, 0, 0, 0, 0, 0, 0, SAOK, 1);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset out_stat", 32'(out_stat), 32'(SAOK));
    checkOutput("reset out_valM", out_valM, 32'd0);

    // Ack without a request does nothing
    mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray ack mem_req", 32'(mem_req), 32'd0);
    checkOutput("stray ack out_valid", 32'(out_valid), 32'd0);
    checkOutput("stray ack in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      finishHandshake(1'b1, $sformatf("vec%0d", i));
    end

    // Back-pressure: outputs frozen while write-back stalls
    out_ready = 1'b0;
    v = mkVec(IIRMOVL, 1, 'h99, 0, 'h8, 0, SAOK, 0, 0, 0, 0, 0, 0, SAOK, 1);
    applyStimulus(v, "stall");
    held_e = out_valE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall out_valE", out_valE, held_e);
      checkOutput("stall out_icode", 32'(out_icode), 32'(IIRMOVL));
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    finishHandshake(1'b1, "stall");

    // Reset in the middle of an outstanding read
    icode = IMRMOVL; valE = 'h40; in_stat = SAOK; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst-in-req mem_req before", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1 checkOutput("rst-in-req mem_req dropped", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst-in-req in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst-in-req out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst-in-req no retry", 32'(mem_req), 32'd0);

    // Call near the top of memory
`ifdef MEM_ADDR_CHECK_EN
    v = mkVec(ICALL, 0, 'hFFE, 'h1, 'h77, 0, SAOK, 0, 0, 0, 0, 0, 0, SADR, 1);
    exp_ready = 1'b0;
`else
    v = mkVec(ICALL, 0, 'hFFE, 'h1, 'h77, 0, SAOK, 0, 1, 1, 'hFFE, 'h77, 0, SAOK, 2);
    exp_ready = 1'b1;
`endif
    applyStimulus(v, "call 0xFFE");
    finishHandshake(exp_ready, "call 0xFFE");
    doReset();

    // Upstream address fault propagates without an access
    v = mkVec(IMRMOVL, 0, 'h10, 0, 0, 0, SADR, 0, 0, 0, 0, 0, 0, SADR, 1);
    applyStimulus(v, "in_stat ADR");
    finishHandshake(1'b0, "in_stat ADR");
    doReset();

    // Undefined opcode
    v = mkVec(4'hC, 0, 'h3, 0, 0, 0, SAOK, 0, 0, 0, 0, 0, 0, SINS, 1);
    applyStimulus(v, "icode C");
    finishHandshake(1'b0, "icode C");
    doReset();

    // Halt locks the stage until reset
    v = mkVec(IHALT, 0, 0, 0, 0, 0, SAOK, 0, 0, 0, 0, 0, 0, SHLT, 1);
    applyStimulus(v, "halt");
    finishHandshake(1'b0, "halt");
    icode = IOPL; in_stat = SAOK; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("halted in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("halted out_valid", 32'(out_valid), 32'd0);
    checkOutput("halted mem_req", 32'(mem_req), 32'd0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
